hit_stun_controller: RTL and testbench
======================================

Name: hit_stun_controller

Overview:
Per-frame sequencer that sits after the two per-direction hit/block detectors (P1 attacking P2, P2 attacking P1). It samples their got_hit/got_blocked results on each game frame tick and enforces one contact per attack. It resolves simultaneous contacts (trades) and runs each player's hitstun/blockstun state machine and countdown. It drives the can-act gating that the player movement/attack logic consumes, and issues one-cycle point pulses to the scoring logic.

Parameters:
HITSTUN_FRAMES, 20, frame ticks a player stays in HITSTUN after an unblocked hit
BLOCKSTUN_FRAMES, 12, frame ticks a player stays in BLOCKSTUN after a blocked hit
CNT_W, 6, stun counter width; both frame counts must be >=1 and <2^CNT_W

Ports:
clk  input  1  system clock, the only clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
frame_tick  input  1  one-cycle pulse per game frame; all state updates occur only on cycles where it is high
p1_got_hit  input  1  P1 hitbox overlaps P2 hurtbox, P2 not blocking (P2 is victim)
p1_got_blocked  input  1  P1 hitbox overlaps P2 hurtbox, P2 blocking
p2_got_hit  input  1  P2 hitbox overlaps P1 hurtbox, P1 not blocking (P1 is victim)
p2_got_blocked  input  1  P2 hitbox overlaps P1 hurtbox, P1 blocking
p1_attack_start  input  1  pulse when P1 begins a new attack; re-arms P1 contact
p2_attack_start  input  1  pulse when P2 begins a new attack; re-arms P2 contact
p1_state  output  2  P1 stun state: 00 FREE, 01 HITSTUN, 10 BLOCKSTUN
p2_state  output  2  P2 stun state, same encoding
p1_stun_cnt  output  CNT_W  P1 remaining stun frames
p2_stun_cnt  output  CNT_W  P2 remaining stun frames
p1_can_act  output  1  high iff p1_state==FREE
p2_can_act  output  1  high iff p2_state==FREE
p1_point  output  1  one-cycle pulse: P1 landed a clean hit
p2_point  output  1  one-cycle pulse: P2 landed a clean hit
trade  output  1  one-cycle pulse: both players hit each other on the same frame

Behaviour:
- Reset (rst_n low at rising clk): both states FREE, counters 0, can_act 1, point/trade 0, both contact latches clear (armed). Reset overrides frame_tick and every other input, including mid-stun.
- Contact latch per attacker: set on any accepted contact (hit or blocked) by that attacker. While set, that attacker's got_hit/got_blocked are ignored. Cleared by that attacker's attack_start. If attack_start and contact occur in the same cycle, the clear applies first and the contact is accepted (latch ends set).
- attack_start is honoured on any cycle; contact inputs are sampled only when frame_tick=1.
- Effective contact for attacker A against victim V, evaluated only on frame_tick with A's latch clear:
  - hit if A_got_hit;
  - hit if A_got_blocked while V is in HITSTUN (no blocking out of hitstun);
  - block if A_got_blocked otherwise;
  - if got_hit and got_blocked are both high, treat as hit.
- Victim update on frame_tick:
  - hit: state<=HITSTUN, cnt<=HITSTUN_FRAMES;
  - block: state<=BLOCKSTUN, cnt<=BLOCKSTUN_FRAMES;
  - no contact and cnt>1: cnt<=cnt-1;
  - no contact and cnt==1: cnt<=0, state<=FREE;
  - FREE with no contact holds cnt at 0.
  - New contact reloads the counter from any state; it does not add to the remaining count, and contact wins over decrement on the same tick.
- Points: accepted hit by P1 with no accepted hit by P2 on the same tick gives p1_point=1 for exactly that cycle; symmetric for P2. Both accept hits on the same tick gives trade=1, no point pulses, and both players enter HITSTUN. Blocks never score. A hit paired with a block on the same tick scores normally.
- Outputs are registered; effects appear the cycle after the frame_tick cycle. Pulse outputs are 0 on every other cycle.
- can_act is combinational from the state register.

Test Plan:
1. Reset, then p1_got_hit on one frame_tick -> next cycle p2_state=01, p2_stun_cnt=20, p1_point=1 for 1 cycle, p2_can_act=0; after 20 further ticks p2_state=00, cnt=0, can_act=1.
2. p1_got_hit held high for 10 ticks without p1_attack_start -> single reload to 20, single p1_point; cnt decrements 19..11. Then pulse p1_attack_start with hit still high -> cnt reloads to 20, second p1_point.
3. p2_got_blocked on a tick, P1 FREE -> p1_state=10, p1_stun_cnt=12, no point; 12 ticks later FREE.
4. p1_got_hit and p2_got_hit on the same tick -> both states 01, both cnt 20, trade=1, p1_point=p2_point=0.
5. P2 in HITSTUN cnt=5, re-armed p1_got_blocked on a tick -> treated as hit: p2_state=01, cnt=20, p1_point=1.
6. rst_n low mid-stun (cnt=7) together with frame_tick and p1_got_hit -> all outputs at reset values next cycle, latches armed.

Source files
------------

// File: rtl/hit_stun_controller.sv
// Per-frame hit/block sequencer: one contact per attack, trade resolution,
// per-player hitstun/blockstun countdown, can-act gating and point pulses.
module hit_stun_controller #(
    parameter int HITSTUN_FRAMES   = 20,
    parameter int BLOCKSTUN_FRAMES = 12,
    parameter int CNT_W            = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             p1_got_hit,
    input  logic             p1_got_blocked,
    input  logic             p2_got_hit,
    input  logic             p2_got_blocked,
    input  logic             p1_attack_start,
    input  logic             p2_attack_start,
    output logic [1:0]       p1_state,
    output logic [1:0]       p2_state,
    output logic [CNT_W-1:0] p1_stun_cnt,
    output logic [CNT_W-1:0] p2_stun_cnt,
    output logic             p1_can_act,
    output logic             p2_can_act,
    output logic             p1_point,
    output logic             p2_point,
    output logic             trade
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'b00,
        ST_HIT   = 2'b01,
        ST_BLOCK = 2'b10
    } stun_e;

    localparam logic [CNT_W-1:0] HIT_LOAD   = CNT_W'(HITSTUN_FRAMES);
    localparam logic [CNT_W-1:0] BLOCK_LOAD = CNT_W'(BLOCKSTUN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    stun_e            p1_st_q, p1_st_d;
    stun_e            p2_st_q, p2_st_d;
    logic [CNT_W-1:0] p1_cnt_q, p1_cnt_d;
    logic [CNT_W-1:0] p2_cnt_q, p2_cnt_d;
    logic             p1_latch_q, p1_latch_d;
    logic             p2_latch_q, p2_latch_d;
    logic             p1_point_q, p1_point_d;
    logic             p2_point_q, p2_point_d;
    logic             trade_q, trade_d;

    logic p1_armed, p2_armed;
    logic p1_hit, p1_blk;
    logic p2_hit, p2_blk;

    // attack_start clears the latch before this cycle's contact is judged,
    // so a same-cycle contact is accepted and re-sets it.
    always_comb begin
        p1_armed = !(p1_latch_q && !p1_attack_start);
        p2_armed = !(p2_latch_q && !p2_attack_start);
        p1_hit   = 1'b0;
        p1_blk   = 1'b0;
        p2_hit   = 1'b0;
        p2_blk   = 1'b0;
        if (frame_tick && p1_armed) begin
            if (p1_got_hit || (p1_got_blocked && p2_st_q == ST_HIT)) begin
                p1_hit = 1'b1;
            end else if (p1_got_blocked) begin
                p1_blk = 1'b1;
            end
        end
        if (frame_tick && p2_armed) begin
            if (p2_got_hit || (p2_got_blocked && p1_st_q == ST_HIT)) begin
                p2_hit = 1'b1;
            end else if (p2_got_blocked) begin
                p2_blk = 1'b1;
            end
        end
    end

    always_comb begin
        p1_latch_d = !p1_armed || p1_hit || p1_blk;
        p2_latch_d = !p2_armed || p2_hit || p2_blk;
        p1_point_d = p1_hit && !p2_hit;
        p2_point_d = p2_hit && !p1_hit;
        trade_d    = p1_hit && p2_hit;
    end

    // P1 is the victim of P2's contacts; a new contact reloads, never adds.
    always_comb begin
        p1_st_d  = p1_st_q;
        p1_cnt_d = p1_cnt_q;
        if (frame_tick) begin
            if (p2_hit) begin
                p1_st_d  = ST_HIT;
                p1_cnt_d = HIT_LOAD;
            end else if (p2_blk) begin
                p1_st_d  = ST_BLOCK;
                p1_cnt_d = BLOCK_LOAD;
            end else if (p1_cnt_q > CNT_ONE) begin
                p1_cnt_d = p1_cnt_q - CNT_ONE;
            end else if (p1_cnt_q == CNT_ONE) begin
                p1_cnt_d = CNT_ZERO;
                p1_st_d  = ST_FREE;
            end
        end
    end

    always_comb begin
        p2_st_d  = p2_st_q;
        p2_cnt_d = p2_cnt_q;
        if (frame_tick) begin
            if (p1_hit) begin
                p2_st_d  = ST_HIT;
                p2_cnt_d = HIT_LOAD;
            end else if (p1_blk) begin
                p2_st_d  = ST_BLOCK;
                p2_cnt_d = BLOCK_LOAD;
            end else if (p2_cnt_q > CNT_ONE) begin
                p2_cnt_d = p2_cnt_q - CNT_ONE;
            end else if (p2_cnt_q == CNT_ONE) begin
                p2_cnt_d = CNT_ZERO;
                p2_st_d  = ST_FREE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_st_q    <= ST_FREE;
            p2_st_q    <= ST_FREE;
            p1_cnt_q   <= CNT_ZERO;
            p2_cnt_q   <= CNT_ZERO;
            p1_latch_q <= 1'b0;
            p2_latch_q <= 1'b0;
            p1_point_q <= 1'b0;
            p2_point_q <= 1'b0;
            trade_q    <= 1'b0;
        end else begin
            p1_st_q    <= p1_st_d;
            p2_st_q    <= p2_st_d;
            p1_cnt_q   <= p1_cnt_d;
            p2_cnt_q   <= p2_cnt_d;
            p1_latch_q <= p1_latch_d;
            p2_latch_q <= p2_latch_d;
            p1_point_q <= p1_point_d;
            p2_point_q <= p2_point_d;
            trade_q    <= trade_d;
        end
    end

    assign p1_state    = p1_st_q;
    assign p2_state    = p2_st_q;
    assign p1_stun_cnt = p1_cnt_q;
    assign p2_stun_cnt = p2_cnt_q;
    assign p1_can_act  = (p1_st_q == ST_FREE);
    assign p2_can_act  = (p2_st_q == ST_FREE);
    assign p1_point    = p1_point_q;
    assign p2_point    = p2_point_q;
    assign trade       = trade_q;

endmodule

// File: tb/tb_hit_stun_controller.sv
// Directed and randomized bench for hit_stun_controller against a
// per-frame rule model of both players.
module tb_hit_stun_controller;

    localparam int HIT_F = 20;
    localparam int BLK_F = 12;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_tick;
    logic          p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked;
    logic          p1_attack_start, p2_attack_start;
    logic [1:0]    p1_state, p2_state;
    logic [CW-1:0] p1_stun_cnt, p2_stun_cnt;
    logic          p1_can_act, p2_can_act, p1_point, p2_point, trade;

    int total = 0;
    int bad   = 0;

    // Model: index 0 = P1, 1 = P2. State codes 0 free, 1 hitstun, 2 blockstun.
    int m_st[2];
    int m_cnt[2];
    int m_latch[2];
    int m_pt[2];
    int m_trade;

    hit_stun_controller #(
        .HITSTUN_FRAMES(HIT_F),
        .BLOCKSTUN_FRAMES(BLK_F),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_tick(frame_tick),
        .p1_got_hit(p1_got_hit),
        .p1_got_blocked(p1_got_blocked),
        .p2_got_hit(p2_got_hit),
        .p2_got_blocked(p2_got_blocked),
        .p1_attack_start(p1_attack_start),
        .p2_attack_start(p2_attack_start),
        .p1_state(p1_state),
        .p2_state(p2_state),
        .p1_stun_cnt(p1_stun_cnt),
        .p2_stun_cnt(p2_stun_cnt),
        .p1_can_act(p1_can_act),
        .p2_can_act(p2_can_act),
        .p1_point(p1_point),
        .p2_point(p2_point),
        .trade(trade)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, ft, input logic gh[2], input logic gb[2],
                              input logic st[2]);
        int hit[2];
        int blk[2];
        if (!r) begin
            for (int p = 0; p < 2; p++) begin
                m_st[p] = 0; m_cnt[p] = 0; m_latch[p] = 0; m_pt[p] = 0;
            end
            m_trade = 0;
            return;
        end
        // Judge both attackers against the pre-tick victim states first.
        for (int a = 0; a < 2; a++) begin
            int busy;
            busy   = (m_latch[a] != 0) && !st[a];
            hit[a] = 0;
            blk[a] = 0;
            if (ft && !busy) begin
                if (gh[a]) hit[a] = 1;
                else if (gb[a]) begin
                    if (m_st[1-a] == 1) hit[a] = 1;
                    else blk[a] = 1;
                end
            end
            m_latch[a] = busy || hit[a] || blk[a];
        end
        for (int v = 0; v < 2; v++) begin
            int a;
            a = 1 - v;
            if (ft) begin
                if (hit[a] != 0) begin
                    m_st[v] = 1; m_cnt[v] = HIT_F;
                end else if (blk[a] != 0) begin
                    m_st[v] = 2; m_cnt[v] = BLK_F;
                end else if (m_cnt[v] > 1) begin
                    m_cnt[v] = m_cnt[v] - 1;
                end else if (m_cnt[v] == 1) begin
                    m_cnt[v] = 0; m_st[v] = 0;
                end
            end
        end
        m_pt[0] = (hit[0] != 0) && (hit[1] == 0);
        m_pt[1] = (hit[1] != 0) && (hit[0] == 0);
        m_trade = (hit[0] != 0) && (hit[1] != 0);
    endtask

    task automatic check_all();
        chk("p1_state", 8'(p1_state), 8'(m_st[0]));
        chk("p2_state", 8'(p2_state), 8'(m_st[1]));
        chk("p1_cnt", 8'(p1_stun_cnt), 8'(m_cnt[0]));
        chk("p2_cnt", 8'(p2_stun_cnt), 8'(m_cnt[1]));
        chk("p1_can_act", 8'(p1_can_act), 8'(m_st[0] == 0));
        chk("p2_can_act", 8'(p2_can_act), 8'(m_st[1] == 0));
        chk("p1_point", 8'(p1_point), 8'(m_pt[0]));
        chk("p2_point", 8'(p2_point), 8'(m_pt[1]));
        chk("trade", 8'(trade), 8'(m_trade));
    endtask

    // One clock: drive inputs, advance model on the edge, check 1ns later.
    task automatic cyc(input logic r, ft, h1, b1, h2, b2, a1, a2);
        logic gh[2];
        logic gb[2];
        logic st[2];
        rst_n = r; frame_tick = ft;
        p1_got_hit = h1; p1_got_blocked = b1;
        p2_got_hit = h2; p2_got_blocked = b2;
        p1_attack_start = a1; p2_attack_start = a2;
        gh[0] = h1; gh[1] = h2;
        gb[0] = b1; gb[1] = b2;
        st[0] = a1; st[1] = a2;
        @(posedge clk);
        model_step(r, ft, gh, gb, st);
        #1;
        check_all();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 1, 1, 1);
        chk("rst_p1_can_act", 8'(p1_can_act), 8'd1);
        chk("rst_p2_cnt", 8'(p2_stun_cnt), 8'd0);

        // Clean hit by P1, then full hitstun countdown
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        chk("t1_p2_state", 8'(p2_state), 8'd1);
        chk("t1_p2_cnt", 8'(p2_stun_cnt), 8'd20);
        chk("t1_p1_point", 8'(p1_point), 8'd1);
        chk("t1_p2_can_act", 8'(p2_can_act), 8'd0);
        idle_ticks(19);
        chk("t1_p2_cnt_last", 8'(p2_stun_cnt), 8'd1);
        idle_ticks(1);
        chk("t1_p2_free", 8'(p2_state), 8'd0);
        chk("t1_p2_can_act_back", 8'(p2_can_act), 8'd1);

        // Held hit counts once; attack_start re-arms it
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        chk("t2_p2_cnt_11", 8'(p2_stun_cnt), 8'd11);
        cyc(1, 1, 1, 0, 0, 0, 1, 0);
        chk("t2_reload", 8'(p2_stun_cnt), 8'd20);
        chk("t2_second_point", 8'(p1_point), 8'd1);
        idle_ticks(22);

        // Block by P1 (P2's first contact), blockstun countdown
        cyc(1, 1, 0, 0, 0, 1, 0, 0);
        chk("t3_p1_state", 8'(p1_state), 8'd2);
        chk("t3_p1_cnt", 8'(p1_stun_cnt), 8'd12);
        chk("t3_no_point", 8'(p2_point), 8'd0);
        idle_ticks(12);
        chk("t3_p1_free", 8'(p1_state), 8'd0);

        // Trade
        cyc(1, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 1, 1, 0, 1, 0, 0, 0);
        chk("t4_trade", 8'(trade), 8'd1);
        chk("t4_p1_cnt", 8'(p1_stun_cnt), 8'd20);
        chk("t4_p1_point", 8'(p1_point), 8'd0);
        idle_ticks(22);

        // Block attempt out of hitstun becomes a hit
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        idle_ticks(15);
        chk("t5_p2_cnt_5", 8'(p2_stun_cnt), 8'd5);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("t5_p2_state", 8'(p2_state), 8'd1);
        chk("t5_p2_cnt", 8'(p2_stun_cnt), 8'd20);
        chk("t5_p1_point", 8'(p1_point), 8'd1);

        // Reset mid-stun beats tick and contact; latches come back armed
        idle_ticks(13);
        chk("t6_p2_cnt_7", 8'(p2_stun_cnt), 8'd7);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        chk("t6_p2_state", 8'(p2_state), 8'd0);
        chk("t6_p2_cnt", 8'(p2_stun_cnt), 8'd0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        chk("t6_rearmed", 8'(p1_point), 8'd1);
        idle_ticks(22);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
